// File: rtl/light_ctrl_pkg.sv
// Shared encodings and helpers for the light input conditioner.
// Exterior select codes, counter sizing and select priority.
package light_ctrl_pkg;

    localparam logic [1:0] EXT_OFF    = 2'b00;
    localparam logic [1:0] EXT_RIGHT  = 2'b01;
    localparam logic [1:0] EXT_LEFT   = 2'b10;
    localparam logic [1:0] EXT_HAZARD = 2'b11;

    // Bits needed for a counter running 0 .. n-1
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Hazard wins; a single stalk selects its side; both or none is off
    function automatic logic [1:0] ext_code(
        input logic hazard_on,
        input logic left,
        input logic right
    );
        logic [1:0] code;
        code = EXT_OFF;
        priority case (1'b1)
            hazard_on:       code = EXT_HAZARD;
            (left & ~right): code = EXT_LEFT;
            (right & ~left): code = EXT_RIGHT;
            default:         code = EXT_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/light_input_conditioner_if.sv
// Switch inputs and conditioned outputs of the light input conditioner.
// master drives the raw switches, slave is the conditioner itself.
interface light_input_conditioner_if;

    logic [3:0] raw_door;
    logic       raw_key;
    logic       stalk_left;
    logic       stalk_right;
    logic       hazard_btn;
    logic [3:0] door;
    logic       key_req;
    logic [1:0] select_ext;
    logic       blink;

    modport master (
        output raw_door, raw_key, stalk_left, stalk_right, hazard_btn,
        input  door, key_req, select_ext, blink
    );

    modport slave (
        input  raw_door, raw_key, stalk_left, stalk_right, hazard_btn,
        output door, key_req, select_ext, blink
    );

endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
// The stable value flips only after DEBOUNCE_CYCLES differing samples.
module switch_debounce
    import light_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous switch into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Count consecutive disagreeing samples; accept the new level on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync[1] == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= sync[1];
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/light_input_conditioner.sv
// Front end of the car light controller: debounce, hazard latch, blink, courtesy.
// LIGHT_COURTESY_EN builds the interior courtesy hold into key_req.
module light_input_conditioner
    import light_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int BLINK_HALF_PERIOD = 8,
    parameter int COURTESY_CYCLES   = 64
) (
    input logic                       clk,
    input logic                       rst_n,
    light_input_conditioner_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2 || BLINK_HALF_PERIOD < 1 ||
        COURTESY_CYCLES < 1) begin : g_bad_cfg
        $error("light_input_conditioner: parameter out of range");
    end

    localparam int BW = cnt_width(BLINK_HALF_PERIOD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

    // bit map: door[3:0], key 4, left 5, right 6, hazard 7
    logic [7:0]    raw;
    logic [7:0]    deb;
    logic          haz_q;
    logic          hazard_on;
    logic          hazard_on_next;
    logic [1:0]    sel;
    logic [1:0]    sel_next;
    logic [BW-1:0] bcnt;
    logic          blink;

    assign raw = {bus.hazard_btn, bus.stalk_right, bus.stalk_left,
                  bus.raw_key, bus.raw_door};

    for (genvar i = 0; i < 8; i++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sw (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw[i]),
            .stable (deb[i])
        );
    end

    // Toggle hazard on each debounced press; holding does not retrigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haz_q     <= 1'b0;
            hazard_on <= 1'b0;
        end else begin
            haz_q     <= deb[7];
            hazard_on <= hazard_on_next;
        end
    end

    // Priority is resolved on the already-toggled hazard state
    assign hazard_on_next = hazard_on ^ (deb[7] & ~haz_q);
    assign sel_next = ext_code(hazard_on_next, deb[5], deb[6]);

    // Select register and blink phase; a fresh activation starts lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= EXT_OFF;
            bcnt  <= '0;
            blink <= 1'b0;
        end else begin
            sel <= sel_next;
            if (sel_next == EXT_OFF) begin
                bcnt  <= '0;
                blink <= 1'b0;
            end else if (sel == EXT_OFF) begin
                bcnt  <= '0;
                blink <= 1'b1;
            end else if (bcnt == BLINK_LAST) begin
                bcnt  <= '0;
                blink <= ~blink;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    assign bus.door       = deb[3:0];
    assign bus.select_ext = sel;
    assign bus.blink      = blink;

`ifdef LIGHT_COURTESY_EN
    localparam int TW = cnt_width(COURTESY_CYCLES);
    // the closing cycle itself is the first hold cycle, so load one less
    localparam logic [TW-1:0] HOLD_LOAD = TW'(COURTESY_CYCLES - 1);

    logic          door_or;
    logic          door_or_q;
    logic          hold;
    logic [TW-1:0] timer;

    assign door_or = |deb[3:0];

    // Courtesy timer: reload on last close, clear on any reopen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door_or_q <= 1'b0;
            timer     <= '0;
        end else begin
            door_or_q <= door_or;
            if (door_or) begin
                timer <= '0;
            end else if (door_or_q) begin
                timer <= HOLD_LOAD;
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

    assign hold        = ~door_or & (door_or_q | (timer != '0));
    assign bus.key_req = deb[4] | hold;
`else
    assign bus.key_req = deb[4];
`endif

endmodule

// File: tb/tb_light_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every cycle,
// a negedge monitor compares the DUT against the queued predictions.
module tb_light_input_conditioner;

    localparam int DEB  = 16;
    localparam int HALF = 8;
    localparam int CYC  = 64;

    typedef struct packed {
        logic [3:0] door;
        logic       key_req;
        logic [1:0] sel;
        logic       blink;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    light_input_conditioner_if bus ();

    light_input_conditioner #(
        .DEBOUNCE_CYCLES   (DEB),
        .BLINK_HALF_PERIOD (HALF),
        .COURTESY_CYCLES   (CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    out_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // reference model state
    logic [7:0] hist[$];
    logic [7:0] deb_m;
    bit         hz_on;
    bit         hz_prev;
    logic [1:0] sel_m;
    int         age;
    bit         blink_m;
    int         since_close;

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s t=%0t actual door=%h key_req=%b sel=%b blink=%b required door=%h key_req=%b sel=%b blink=%b",
                     name, $time, act.door, act.key_req, act.sel, act.blink,
                     exp.door, exp.key_req, exp.sel, exp.blink);
        end
    endtask

    // Model: predict outputs after each rising edge from the sampled inputs
    always @(posedge clk) begin : model
        out_t       e;
        logic [7:0] old;
        logic [7:0] s;
        logic [1:0] nsel;
        bit         same;
        e = '0;
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < DEB + 1; i++) hist.push_back(8'h00);
            deb_m       = '0;
            hz_on       = 0;
            hz_prev     = 0;
            sel_m       = 2'b00;
            age         = 0;
            blink_m     = 0;
            since_close = CYC;
        end else begin
            hist.push_back({bus.hazard_btn, bus.stalk_right, bus.stalk_left,
                            bus.raw_key, bus.raw_door});
            if (hist.size() > DEB + 2) void'(hist.pop_front());
            old = deb_m;
            // a level is accepted once the last DEB synchronised samples all show it
            for (int b = 0; b < 8; b++) begin
                same = 1;
                for (int i = 0; i < DEB; i++) begin
                    s = hist[i];
                    if (s[b] != hist[DEB-1][b]) same = 0;
                end
                if (same) deb_m[b] = hist[DEB-1][b];
            end
            if (old[7] && !hz_prev) hz_on = !hz_on;
            hz_prev = old[7];
            if (hz_on) nsel = 2'b11;
            else if (old[5] && !old[6]) nsel = 2'b10;
            else if (old[6] && !old[5]) nsel = 2'b01;
            else nsel = 2'b00;
            if (nsel == 2'b00) begin
                age = 0;
                blink_m = 0;
            end else if (sel_m == 2'b00) begin
                age = 0;
                blink_m = 1;
            end else begin
                age++;
                blink_m = ((age / HALF) % 2) == 0;
            end
            sel_m = nsel;
`ifdef LIGHT_COURTESY_EN
            if (deb_m[3:0] != 4'h0) since_close = CYC;
            else if (old[3:0] != 4'h0) since_close = 0;
            else if (since_close < CYC) since_close++;
            e.key_req = deb_m[4] || (since_close < CYC);
`else
            e.key_req = deb_m[4];
`endif
            e.door  = deb_m[3:0];
            e.sel   = sel_m;
            e.blink = blink_m;
        end
        exp_q.push_back(e);
    end

    // Monitor: outputs are presented every cycle, compare at the falling edge
    always @(negedge clk) begin : monitor
        out_t e;
        out_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.door, bus.key_req, bus.select_ext, bus.blink};
            check("cycle", a, e);
        end
    end

    logic [7:0] rv;

    task automatic apply(input logic [7:0] v);
        {bus.hazard_btn, bus.stalk_right, bus.stalk_left,
         bus.raw_key, bus.raw_door} = v;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            apply(rv);
        end
    endtask

    initial begin : stim
        out_t       z;
        logic [7:0] drv;
        int         k;
        z  = '0;
        rv = 8'h00;
        apply(rv);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // bouncing door, then held open
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) rv[2] = ~rv[2];
            run(1);
        end
        rv[2] = 1'b1;
        run(30);

        // left turn, then both stalks, then none
        rv[5] = 1'b1;
        run(40);
        rv[6] = 1'b1;
        run(30);
        rv[5] = 1'b0;
        rv[6] = 1'b0;
        run(30);

        // hazard over a right turn, two presses
        rv[6] = 1'b1;
        run(30);
        rv[7] = 1'b1;
        run(30);
        rv[7] = 1'b0;
        run(40);
        rv[7] = 1'b1;
        run(30);
        rv[7] = 1'b0;
        run(40);
        rv[6] = 1'b0;
        run(30);

        // courtesy: close, full hold; reopen mid-hold; close again
        rv[3:0] = 4'h0;
        run(100);
        rv[1] = 1'b1;
        run(30);
        rv[1] = 1'b0;
        run(30);
        rv[0] = 1'b1;
        run(40);
        rv[0] = 1'b0;
        run(100);

        // third press: hazard on, then reset while blinking
        rv[7] = 1'b1;
        run(30);
        rv[7] = 1'b0;
        run(30);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset",
                 {bus.door, bus.key_req, bus.select_ext, bus.blink}, z);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        run(30);

        // random switches with occasional single-cycle glitches
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 59) == 0) rv[b] = ~rv[b];
            end
            drv = rv;
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(0, 7);
                drv[k] = ~drv[k];
            end
            @(posedge clk);
            #2;
            apply(drv);
        end
        run(60);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
